pwm_duty_ramp: RTL and testbench
================================

// Module: pwm_duty_ramp
// PURPOSE
//   Upstream duty-cycle conditioner for the pwm stage. Synchronises and debounces the raw
//   duty switches, then slews the duty word one LSB per STEP_CYCLES toward the debounced
//   target (soft start / soft stop), so pwm.sw never sees glitches or step jumps.
// PARAMETERS
//   bits             4   width of duty word; must match pwm #(.bits)
//   DEBOUNCE_CYCLES  16  cycles sw must be stable before target updates (>=2)
//   STEP_CYCLES      64  cycles between successive 1-LSB duty steps (>=2)
// PORTS
//   clk   in   1     block clock, rising edge
//   rst   in   1     synchronous, active-high reset
//   sw    in   bits  raw asynchronous duty request (switches)
//   duty  out  bits  conditioned duty word, registered; drives pwm.sw
//   busy  out  1     1 while ramping (state != IDLE)
//   done  out  1     one-cycle pulse on the step that makes duty == target
// BEHAVIOUR
//   Interface: one clock; reset is synchronous and active-high (clk, rst).
//   Reset (rst=1 at an edge): s1,s2,cand,target,duty <= 0; dbcnt,tmr <= 0; state <= IDLE;
//     busy=0, done=0. Reset mid-ramp aborts immediately; duty returns to 0, no done pulse.
//   Sync: s1<=sw, s2<=s1 (2 flops); only s2 is used downstream.
//   Debounce: if s2!=cand: cand<=s2, dbcnt<=0. Else if dbcnt==DEBOUNCE_CYCLES-1:
//     target<=cand, dbcnt holds. Else dbcnt<=dbcnt+1.
//     -> sw change held stable updates target exactly DEBOUNCE_CYCLES+3 edges later;
//        any bounce shorter than that restarts the count; target never changes.
//   FSM states: IDLE, UP, DOWN.
//     IDLE: target>duty -> UP; target<duty -> DOWN; tmr<=0. equal -> stay.
//     UP/DOWN: tmr increments; when tmr==STEP_CYCLES-1: tmr<=0 and
//       UP: if target>duty: duty<=duty+1; DOWN: if target<duty: duty<=duty-1.
//       If the new duty==target: state<=IDLE, done<=1 for that one cycle.
//       If at a step tick the target has moved behind duty (direction wrong or equal):
//       no step, state<=IDLE (re-evaluated next cycle; reversal costs 1 cycle + STEP).
//   First step lands STEP_CYCLES edges after entering UP/DOWN; then every STEP_CYCLES.
//   Arithmetic: duty saturates at 0 and 2^bits-1; never wraps (guaranteed by compare).
//   busy == (state!=IDLE), registered with state. done otherwise 0.
//   Target changes mid-ramp in same direction: ramp continues to new target, no restart
//   of tmr.
// TESTING (bits=4, DEBOUNCE_CYCLES=4, STEP_CYCLES=8)
//   1 rst 2 cycles -> duty=0,busy=0,done=0; sw=4'hF during rst has no effect.
//   2 sw 0->9 held -> target=9 at +7 edges; busy 1 next edge; duty 1..9 every 8 cycles;
//     done pulses once with duty=9, busy=0 same cycle; total 72 cycles after busy rises.
//   3 sw toggles 3/0 every 3 cycles for 30 cycles -> target, duty stay 0, busy stays 0.
//   4 ramp 0->15, change sw to 2 when duty=6 -> duty peaks <=7, falls to 2, single done
//     at duty=2, never exceeds 15 or wraps.
//   5 from duty=15 set sw=0 -> 15 DOWN steps to 0, saturates at 0, one done pulse.
//   6 rst asserted mid-ramp (duty=5) -> next edge duty=0,busy=0,done=0,target=0.

Source files
------------

// File: rtl/pwm_duty_ramp_if.sv
// Duty-conditioner bus.
// The master drives the raw switch request.
// The slave (pwm_duty_ramp) returns the conditioned duty word and the ramp status.
//   sw    master->slave  bits  raw asynchronous duty request
//   duty  slave->master  bits  conditioned duty word
//   busy  slave->master  1     ramp in progress
//   done  slave->master  1     one-cycle pulse when duty reaches target
interface pwm_duty_ramp_if #(
    parameter int bits = 4
);
    logic [bits-1:0] sw;
    logic [bits-1:0] duty;
    logic            busy;
    logic            done;

    modport master (output sw, input duty, input busy, input done);
    modport slave  (input sw, output duty, output busy, output done);
endinterface

// File: rtl/pwm_duty_ramp.sv
// Upstream duty-cycle conditioner for the pwm stage.
// The raw duty switches are synchronised and debounced into a target word.
// The duty word is then slewed one LSB every STEP_CYCLES toward that target,
// which gives soft start and soft stop, so the pwm stage never sees glitches
// or step jumps.
//   clk  in     block clock, rising edge
//   rst  in     synchronous, active-high reset
//   bus  slave  sw in; duty, busy, done out (all outputs registered)
//
// state | meaning
// IDLE  | duty == target, or waiting one cycle to pick a ramp direction
// UP    | stepping duty up toward target every STEP_CYCLES
// DOWN  | stepping duty down toward target every STEP_CYCLES
module pwm_duty_ramp #(
    parameter int bits            = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STEP_CYCLES     = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    pwm_duty_ramp_if.slave       bus
);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES);
    localparam int TMW = $clog2(STEP_CYCLES);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMW-1:0] ST_LAST = TMW'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    logic [bits-1:0] s1, s2, cand, target, duty;
    logic [DBW-1:0]  dbcnt;
    logic [TMW-1:0]  tmr;
    state_t          state;
    logic            busy, done;

    assign bus.duty = duty;
    assign bus.busy = busy;
    assign bus.done = done;

    // Two-flop synchroniser followed by a stability counter.
    // The counter saturates at DB_LAST, so target keeps tracking cand while
    // the input stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= '0;
            s2     <= '0;
            cand   <= '0;
            target <= '0;
            dbcnt  <= '0;
        end else begin
            s1 <= bus.sw;
            s2 <= s1;
            if (s2 != cand) begin
                cand  <= s2;
                dbcnt <= '0;
            end else if (dbcnt == DB_LAST) begin
                target <= cand;
            end else begin
                dbcnt <= dbcnt + DBW'(1);
            end
        end
    end

    // Saturation at 0 and full scale falls out of the strict target
    // compares: duty only moves while it is strictly short of target.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            duty  <= '0;
            tmr   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tmr <= '0;
                    if (target > duty) begin
                        state <= UP;
                        busy  <= 1'b1;
                    end else if (target < duty) begin
                        state <= DOWN;
                        busy  <= 1'b1;
                    end
                end
                UP: begin
                    if (tmr == ST_LAST) begin
                        tmr <= '0;
                        if (target > duty) begin
                            duty <= duty + bits'(1);
                            if ((duty + bits'(1)) == target) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            // Target moved behind us; let IDLE pick the new direction.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        tmr <= tmr + TMW'(1);
                    end
                end
                DOWN: begin
                    if (tmr == ST_LAST) begin
                        tmr <= '0;
                        if (target < duty) begin
                            duty <= duty - bits'(1);
                            if ((duty - bits'(1)) == target) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        tmr <= tmr + TMW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp with bits=4, DEBOUNCE_CYCLES=4, STEP_CYCLES=8.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_pwm_duty_ramp;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    pwm_duty_ramp_if #(.bits(4)) bus();

    pwm_duty_ramp #(
        .bits(4),
        .DEBOUNCE_CYCLES(4),
        .STEP_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int c;
        int peak, done_cnt, done_at, done_duty, wraps, prev;

        // 1: reset, switches high during reset are ignored
        rst = 1'b1;
        bus.sw = 4'hF;
        tick(2);
        chk("rst_duty", bus.duty, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_target", dut.target, 0);
        bus.sw = 4'h0;
        tick(1);
        rst = 1'b0;
        tick(10);
        chk("post_rst_target", dut.target, 0);
        chk("post_rst_busy", bus.busy, 0);

        // 3: bounce of 3-cycle periods never settles the debouncer
        for (int i = 0; i < 10; i++) begin
            bus.sw = (i % 2 == 0) ? 4'h3 : 4'h0;
            tick(3);
            chk("bounce_target", dut.target, 0);
            chk("bounce_busy", bus.busy, 0);
        end
        bus.sw = 4'h0;
        tick(10);
        chk("bounce_end_target", dut.target, 0);
        chk("bounce_end_duty", bus.duty, 0);

        // 2: ramp 0 -> 9
        bus.sw = 4'h9;
        tick(6);
        chk("ramp9_target_early", dut.target, 0);
        tick(1);
        chk("ramp9_target", dut.target, 9);
        chk("ramp9_busy_pre", bus.busy, 0);
        tick(1);
        chk("ramp9_busy_rise", bus.busy, 1);
        chk("ramp9_duty_start", bus.duty, 0);
        for (int k = 1; k <= 9; k++) begin
            tick(7);
            chk("ramp9_hold", bus.duty, k - 1);
            chk("ramp9_hold_busy", bus.busy, 1);
            tick(1);
            chk("ramp9_step", bus.duty, k);
            chk("ramp9_done", bus.done, (k == 9) ? 1 : 0);
            chk("ramp9_busy", bus.busy, (k != 9) ? 1 : 0);
        end
        tick(1);
        chk("ramp9_done_clear", bus.done, 0);
        chk("ramp9_final", bus.duty, 9);

        // 4: ramp toward 15, retarget to 2 once duty reaches 6
        rst = 1'b1;
        tick(1);
        chk("r4_rst_duty", bus.duty, 0);
        rst = 1'b0;
        bus.sw = 4'hF;
        c = 0;
        while (bus.duty != 4'h6 && c < 100) begin
            tick(1);
            c++;
        end
        chk("r4_reach6_cycles", c, 56);
        bus.sw = 4'h2;
        peak = 6; done_cnt = 0; done_at = 0; done_duty = 0;
        for (int i = 1; i <= 60; i++) begin
            tick(1);
            if (int'(bus.duty) > peak) peak = int'(bus.duty);
            if (bus.done) begin
                done_cnt++;
                done_at = i;
                done_duty = int'(bus.duty);
            end
        end
        chk("r4_peak", peak, 6);
        chk("r4_done_cnt", done_cnt, 1);
        chk("r4_done_at", done_at, 41);
        chk("r4_done_duty", done_duty, 2);
        chk("r4_final_duty", bus.duty, 2);
        chk("r4_final_busy", bus.busy, 0);

        // 5: full-scale ramp up, then all the way down with saturation at 0
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        bus.sw = 4'hF;
        tick(128);
        chk("r5_top_duty", bus.duty, 15);
        chk("r5_top_done", bus.done, 1);
        chk("r5_top_busy", bus.busy, 0);
        tick(1);
        chk("r5_top_done_clear", bus.done, 0);
        bus.sw = 4'h0;
        done_cnt = 0; done_at = 0; wraps = 0; prev = 15;
        for (int i = 1; i <= 140; i++) begin
            tick(1);
            if (int'(bus.duty) > prev) wraps++;
            prev = int'(bus.duty);
            if (bus.done) begin
                done_cnt++;
                done_at = i;
            end
        end
        chk("r5_wraps", wraps, 0);
        chk("r5_done_cnt", done_cnt, 1);
        chk("r5_done_at", done_at, 128);
        chk("r5_bottom_duty", bus.duty, 0);
        chk("r5_bottom_busy", bus.busy, 0);

        // 6: reset mid-ramp at duty 5
        bus.sw = 4'h9;
        c = 0;
        while (bus.duty != 4'h5 && c < 100) begin
            tick(1);
            c++;
        end
        chk("r6_reach5_cycles", c, 48);
        rst = 1'b1;
        tick(1);
        chk("r6_duty", bus.duty, 0);
        chk("r6_busy", bus.busy, 0);
        chk("r6_done", bus.done, 0);
        chk("r6_target", dut.target, 0);
        bus.sw = 4'h0;
        rst = 1'b0;
        tick(12);
        chk("r6_after_duty", bus.duty, 0);
        chk("r6_after_busy", bus.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
